// File: rtl/sw_led_pio.sv
// Switch/LED peripheral: synchronised, debounced switches with edge capture and irq,
// plus per-channel LED drive (software data, blink, or switch pass-through) over Avalon-MM.
module sw_led_pio #(
  parameter int NUM_CH            = 2,
  parameter int DEBOUNCE_CYCLES   = 500000,
  parameter int BLINK_HALF_CYCLES = 12500000,
  parameter int EDGE_MODE         = 2,
  parameter int LED_ACTIVE_LOW    = 0
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic [NUM_CH-1:0] sw_in,
  output logic [NUM_CH-1:0] led_out,
  input  logic [2:0]        avs_address,
  input  logic              avs_chipselect,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  output logic [31:0]       avs_readdata,
  output logic              irq
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int BLK_W = (BLINK_HALF_CYCLES > 2) ? $clog2(BLINK_HALF_CYCLES) : 1;
  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_HALF_CYCLES - 1);
  localparam logic [NUM_CH-1:0] LED_OFF = {NUM_CH{LED_ACTIVE_LOW != 0}};

  function automatic logic [31:0] zext(input logic [NUM_CH-1:0] v);
    return {{(32-NUM_CH){1'b0}}, v};
  endfunction

  logic [NUM_CH-1:0] sw_p0, sw_p1, stable;
  logic [CNT_W-1:0]  db_cnt [NUM_CH];
  logic [NUM_CH-1:0] accept, edge_set;
  logic [NUM_CH-1:0] edge_cap, irq_mask, led_data, led_blink, led_pass;
  logic [BLK_W-1:0]  blk_cnt;
  logic              blink_phase;
  logic [NUM_CH-1:0] led_sel, w1c, wdata_ch;
  logic [31:0]       rd_word;
  logic              wr_en, rd_en;
  logic              unused_wdata;

  assign wr_en        = avs_chipselect & avs_write;
  assign rd_en        = avs_chipselect & avs_read;
  assign wdata_ch     = avs_writedata[NUM_CH-1:0];
  assign unused_wdata = ^avs_writedata[31:NUM_CH];
  assign w1c          = (wr_en && avs_address == 3'd1) ? wdata_ch : '0;

  always_comb begin
    accept   = '0;
    edge_set = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      accept[i] = (sw_p1[i] != stable[i]) && (db_cnt[i] == DB_LAST);
      if (accept[i]) begin
        case (EDGE_MODE)
          0:       edge_set[i] = sw_p1[i];
          1:       edge_set[i] = ~sw_p1[i];
          default: edge_set[i] = 1'b1;
        endcase
      end
    end
  end

  always_comb begin
    led_sel = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (led_pass[i])       led_sel[i] = stable[i];
      else if (led_blink[i]) led_sel[i] = led_data[i] & blink_phase;
      else                   led_sel[i] = led_data[i];
    end
  end

  always_comb begin
    rd_word = '0;
    case (avs_address)
      3'd0:    rd_word = zext(stable);
      3'd1:    rd_word = zext(edge_cap);
      3'd2:    rd_word = zext(irq_mask);
      3'd3:    rd_word = zext(led_data);
      3'd4:    rd_word = zext(led_blink);
      3'd5:    rd_word = zext(led_pass);
      default: rd_word = '0;
    endcase
  end

  // sw_p0/sw_p1: two-flop synchroniser; stable: debounced level
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      sw_p0  <= '0;
      sw_p1  <= '0;
      stable <= '0;
      for (int i = 0; i < NUM_CH; i++) db_cnt[i] <= '0;
    end else begin
      sw_p0 <= sw_in;
      sw_p1 <= sw_p0;
      for (int i = 0; i < NUM_CH; i++) begin
        if (sw_p1[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (accept[i]) begin
          stable[i] <= sw_p1[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Register file, blink timebase and registered outputs
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      edge_cap     <= '0;
      irq_mask     <= '0;
      led_data     <= '0;
      led_blink    <= '0;
      led_pass     <= '0;
      blk_cnt      <= '0;
      blink_phase  <= 1'b0;
      avs_readdata <= '0;
      irq          <= 1'b0;
      led_out      <= LED_OFF;
    end else begin
      // a new edge beats a coincident write-1-clear
      edge_cap <= (edge_cap & ~w1c) | edge_set;
      if (wr_en) begin
        case (avs_address)
          3'd2:    irq_mask  <= wdata_ch;
          3'd3:    led_data  <= wdata_ch;
          3'd4:    led_blink <= wdata_ch;
          3'd5:    led_pass  <= wdata_ch;
          default: ;
        endcase
      end
      if (blk_cnt == BLK_LAST) begin
        blk_cnt     <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blk_cnt <= blk_cnt + BLK_W'(1);
      end
      if (rd_en) avs_readdata <= rd_word;
      irq     <= |(edge_cap & irq_mask);
      led_out <= led_sel ^ LED_OFF;
    end
  end

endmodule

// File: tb/tb_sw_led_pio.sv
// Bench for sw_led_pio: two instances (active-high and active-low LEDs) driven in parallel,
// checked every cycle against a behavioural model plus hand-computed directed expectations.
module tb_sw_led_pio;

  localparam int D = 4;
  localparam int H = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  sw_in = '0;
  logic [2:0]  addr = '0;
  logic        cs = 1'b0, rd_s = 1'b0, wr_s = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] readdata, readdata_al;
  logic [1:0]  led, led_al;
  logic        irq, irq_al;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sw_led_pio #(.NUM_CH(2), .DEBOUNCE_CYCLES(D), .BLINK_HALF_CYCLES(H),
               .EDGE_MODE(2), .LED_ACTIVE_LOW(0)) dut (
    .clk_clk(clk), .reset_reset_n(rst_n), .sw_in(sw_in), .led_out(led),
    .avs_address(addr), .avs_chipselect(cs), .avs_read(rd_s), .avs_write(wr_s),
    .avs_writedata(wdata), .avs_readdata(readdata), .irq(irq));

  sw_led_pio #(.NUM_CH(2), .DEBOUNCE_CYCLES(D), .BLINK_HALF_CYCLES(H),
               .EDGE_MODE(2), .LED_ACTIVE_LOW(1)) dut_al (
    .clk_clk(clk), .reset_reset_n(rst_n), .sw_in(sw_in), .led_out(led_al),
    .avs_address(addr), .avs_chipselect(cs), .avs_read(rd_s), .avs_write(wr_s),
    .avs_writedata(wdata), .avs_readdata(readdata_al), .irq(irq_al));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: pin seen 2 edges late, accepted after D consecutive
  // differing samples; blink phase after k edges is (k/H) mod 2.
  logic [1:0]  m_s1 = '0, m_s2 = '0, m_stable = '0, m_cap = '0;
  logic [1:0]  m_mask = '0, m_data = '0, m_blink = '0, m_pass = '0, m_led = '0;
  logic        m_irq = 1'b0;
  logic [31:0] m_rd = '0;
  int          m_run [2];
  int          m_k = 0;

  function automatic logic [31:0] reg_word(input logic [2:0] a);
    case (a)
      3'd0: return {30'b0, m_stable};
      3'd1: return {30'b0, m_cap};
      3'd2: return {30'b0, m_mask};
      3'd3: return {30'b0, m_data};
      3'd4: return {30'b0, m_blink};
      3'd5: return {30'b0, m_pass};
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk) begin : model
    logic [1:0] n_stable, n_led, set_b, w1c;
    logic       ph;
    if (!rst_n) begin
      m_s1 = '0; m_s2 = '0; m_stable = '0; m_cap = '0; m_mask = '0;
      m_data = '0; m_blink = '0; m_pass = '0; m_led = '0; m_irq = 1'b0;
      m_rd = '0; m_run[0] = 0; m_run[1] = 0; m_k = 0;
    end else begin
      if (cs && rd_s) m_rd = reg_word(addr);
      ph = ((m_k / H) % 2) == 1;
      for (int i = 0; i < 2; i++)
        n_led[i] = m_pass[i] ? m_stable[i] : (m_blink[i] ? (m_data[i] & ph) : m_data[i]);
      m_irq = |(m_cap & m_mask);
      n_stable = m_stable;
      set_b = '0;
      for (int i = 0; i < 2; i++) begin
        if (m_s2[i] != m_stable[i]) begin
          m_run[i] = m_run[i] + 1;
          if (m_run[i] == D) begin
            n_stable[i] = m_s2[i];
            m_run[i] = 0;
            set_b[i] = 1'b1;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      w1c = (cs && wr_s && addr == 3'd1) ? wdata[1:0] : 2'b00;
      m_cap = (m_cap & ~w1c) | set_b;
      if (cs && wr_s) begin
        case (addr)
          3'd2: m_mask  = wdata[1:0];
          3'd3: m_data  = wdata[1:0];
          3'd4: m_blink = wdata[1:0];
          3'd5: m_pass  = wdata[1:0];
          default: ;
        endcase
      end
      m_stable = n_stable;
      m_led = n_led;
      m_s2 = m_s1;
      m_s1 = sw_in;
      m_k = m_k + 1;
    end
  end

  always @(posedge clk) begin
    #1;
    check("cyc_led_out", {30'b0, led}, {30'b0, m_led});
    check("cyc_led_out_al", {30'b0, led_al}, {30'b0, ~m_led});
    check("cyc_irq", {31'b0, irq}, {31'b0, m_irq});
    check("cyc_irq_al", {31'b0, irq_al}, {31'b0, m_irq});
    check("cyc_readdata", readdata, m_rd);
    check("cyc_readdata_al", readdata_al, m_rd);
  end

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    cs = 1'b1; wr_s = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    cs = 1'b0; wr_s = 1'b0; wdata = '0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] v);
    cs = 1'b1; rd_s = 1'b1; addr = a;
    @(negedge clk);
    v = readdata;
    cs = 1'b0; rd_s = 1'b0;
  endtask

  initial begin
    logic [31:0] v;
    logic        prev;
    bit          seen;

    // Reset
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("reset_led", {30'b0, led}, 32'h0);
    check("reset_led_al", {30'b0, led_al}, 32'h3);
    check("reset_irq", {31'b0, irq}, 32'h0);
    for (int a = 0; a < 8; a++) begin
      rd(3'(a), v);
      check($sformatf("reset_read_addr%0d", a), v, 32'h0);
    end

    // Debounce: clean rising edge on channel 0
    sw_in[0] = 1'b1;
    repeat (5) @(negedge clk);
    rd(3'd0, v); check("sw_state_before_accept", v, 32'h0);
    rd(3'd0, v); check("sw_state_accepted", v, 32'h1);
    rd(3'd1, v); check("edge_cap_rise", v, 32'h1);

    // 3-cycle glitch on channel 1 is rejected
    sw_in[1] = 1'b1;
    repeat (3) @(negedge clk);
    sw_in[1] = 1'b0;
    repeat (8) @(negedge clk);
    rd(3'd0, v); check("glitch_sw_state", v, 32'h1);
    rd(3'd1, v); check("glitch_edge_cap", v, 32'h1);

    // IRQ and write-1-clear
    wr(3'd1, 32'h3);
    wr(3'd2, 32'h1);
    sw_in[0] = 1'b0;
    repeat (6) @(negedge clk);
    check("irq_same_cycle_as_capture", {31'b0, irq}, 32'h0);
    @(negedge clk);
    check("irq_after_capture", {31'b0, irq}, 32'h1);
    wr(3'd1, 32'h1);
    check("irq_on_clear_edge", {31'b0, irq}, 32'h1);
    @(negedge clk);
    check("irq_after_clear", {31'b0, irq}, 32'h0);

    // W1C coincident with a new edge: the set wins
    sw_in[0] = 1'b1;
    repeat (5) @(negedge clk);
    wr(3'd1, 32'h1);
    rd(3'd1, v); check("w1c_vs_set", v, 32'h1);
    check("irq_after_w1c_vs_set", {31'b0, irq}, 32'h1);

    // LED modes: channel 0 blinks, channel 1 steady
    wr(3'd3, 32'h3);
    wr(3'd4, 32'h1);
    repeat (2) @(negedge clk);
    check("led1_steady", {31'b0, led[1]}, 32'h1);
    seen = 1'b0;
    prev = led[0];
    for (int c = 0; c < 8 && !seen; c++) begin
      @(negedge clk);
      if (led[0] != prev) seen = 1'b1;
      prev = led[0];
    end
    check("blink_toggle_seen", {31'b0, seen}, 32'h1);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check($sformatf("blink_led0_k%0d", k), {31'b0, led[0]},
            {31'b0, (k == 3) ? ~prev : prev});
    end

    // Pass-through on channel 1
    sw_in[1] = 1'b1;
    repeat (10) @(negedge clk);
    wr(3'd5, 32'h2);
    sw_in[1] = 1'b0;
    repeat (6) @(negedge clk);
    check("pass_led1_before", {31'b0, led[1]}, 32'h1);
    @(negedge clk);
    check("pass_led1_after", {31'b0, led[1]}, 32'h0);

    // Active-low polarity
    wr(3'd5, 32'h0);
    wr(3'd4, 32'h0);
    wr(3'd3, 32'h1);
    @(negedge clk);
    check("led_data_01", {30'b0, led}, 32'h1);
    check("led_data_01_al", {30'b0, led_al}, 32'h2);

    // Reset in the middle of a debounce count
    sw_in[0] = 1'b0;
    repeat (8) @(negedge clk);
    rd(3'd0, v); check("pre_midreset_state", v, 32'h0);
    sw_in[0] = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    rd(3'd0, v); check("midreset_before_accept", v, 32'h0);
    rd(3'd0, v); check("midreset_accepted", v, 32'h1);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
